// File: rtl/picosoc_iomux_pkg.sv
// Shared types and constants for the picosoc_iomux peripheral interconnect.
package picosoc_iomux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        DONE   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_DECODE  = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_cause_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic logic win_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
        return ((addr & mask) == (base & mask));
    endfunction

endpackage

// File: rtl/picosoc_iomux_decode.sv
// Combinational address decoder: first matching window wins, lowest index first.
module picosoc_iomux_decode
    import picosoc_iomux_pkg::*;
#(
    parameter int                    NSLAVES    = 4,
    parameter logic [NSLAVES*32-1:0] SLAVE_BASE = {32'h0300_0000, 32'h0200_0000, 32'h0200_0010, 32'h0200_0000},
    parameter logic [NSLAVES*32-1:0] SLAVE_MASK = {4{32'hFF00_0000}},
    parameter int                    IDX_W      = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
) (
    input  logic [31:0]      i_addr,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_sel_idx
);

    // Scan from the top so the lowest matching index is written last.
    always_comb begin
        o_hit     = 1'b0;
        o_sel_idx = {IDX_W{1'b0}};
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if (win_hit(i_addr, SLAVE_BASE[32*i +: 32], SLAVE_MASK[32*i +: 32])) begin
                o_hit     = 1'b1;
                o_sel_idx = IDX_W'(i);
            end else begin
                o_hit     = o_hit;
                o_sel_idx = o_sel_idx;
            end
        end
    end

endmodule

// File: rtl/picosoc_iomux.sv
// PicoRV32 native-bus to NSLAVES peripheral interconnect with a registered
// request stage, per-transaction timeout and unmapped-address error reporting.
module picosoc_iomux
    import picosoc_iomux_pkg::*;
#(
    parameter int                    NSLAVES    = 4,
    parameter logic [NSLAVES*32-1:0] SLAVE_BASE = {32'h0300_0000, 32'h0200_0000, 32'h0200_0010, 32'h0200_0000},
    parameter logic [NSLAVES*32-1:0] SLAVE_MASK = {4{32'hFF00_0000}},
    parameter int                    TIMEOUT    = 255,
    parameter logic [31:0]           ERR_RDATA  = ERR_RDATA_DEFAULT
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wstrb,
    output logic [31:0]             mem_rdata,
    output logic [NSLAVES-1:0]      s_valid,
    input  logic [NSLAVES-1:0]      s_ready,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic [3:0]              s_wstrb,
    input  logic [NSLAVES*32-1:0]   s_rdata,
    output logic                    err_irq,
    output logic [31:0]             err_addr,
    output logic [1:0]              err_cause,
    input  logic                    err_clear
);

    localparam int IDX_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_sel;
    logic [NSLAVES-1:0] r_s_valid;
    logic [31:0]        r_s_addr;
    logic [31:0]        r_s_wdata;
    logic [3:0]         r_s_wstrb;
    logic               r_mem_ready;
    logic [31:0]        r_mem_rdata;
    logic               r_err_irq;
    logic [31:0]        r_err_addr;
    err_cause_t         r_err_cause;

    logic               w_hit;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_sel_ready;
    logic [31:0]        w_sel_rdata;
    logic               w_timeout;
    logic               w_accept;
    logic               w_decode_err;
    logic               w_complete;
    logic               w_abort;

    picosoc_iomux_decode #(
        .NSLAVES    (NSLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK),
        .IDX_W      (IDX_W)
    ) u_decode (
        .i_addr    (mem_addr),
        .o_hit     (w_hit),
        .o_sel_idx (w_sel_idx)
    );

    // Only the selected slave's handshake and data matter; the rest are ignored.
    assign w_sel_ready = s_ready[r_sel];
    assign w_sel_rdata = s_rdata[32*r_sel +: 32];

    generate
        if (TIMEOUT > 0) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            // Counts ACTIVE cycles; parked at zero in every other state.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_cnt <= {CNT_W{1'b0}};
                end else if (r_state == ACTIVE) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else begin
                    r_cnt <= {CNT_W{1'b0}};
                end
            end

            assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_cnt
            assign w_timeout = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Transaction events; s_ready beats a simultaneous timeout.
    always_comb begin
        w_accept     = 1'b0;
        w_decode_err = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept     = mem_valid & w_hit;
                w_decode_err = mem_valid & ~w_hit;
            end
            ACTIVE: begin
                w_complete = w_sel_ready;
                w_abort    = ~w_sel_ready & w_timeout;
            end
            DONE: begin
                w_accept = 1'b0;
            end
            default: begin
                w_accept = 1'b0;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = ACTIVE;
                end else if (w_decode_err) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ACTIVE: begin
                if (w_complete || w_abort) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = ACTIVE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Request stage toward the slaves, held stable for the whole transaction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sel     <= {IDX_W{1'b0}};
            r_s_valid <= {NSLAVES{1'b0}};
            r_s_addr  <= 32'h0000_0000;
            r_s_wdata <= 32'h0000_0000;
            r_s_wstrb <= 4'b0000;
        end else if (w_accept) begin
            r_sel     <= w_sel_idx;
            r_s_valid <= NSLAVES'(1) << w_sel_idx;
            r_s_addr  <= mem_addr;
            r_s_wdata <= mem_wdata;
            r_s_wstrb <= mem_wstrb;
        end else if (w_complete || w_abort) begin
            r_s_valid <= {NSLAVES{1'b0}};
        end else begin
            r_s_valid <= r_s_valid;
        end
    end

    // CPU response and error reporting; a new error overrides err_clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_ready <= 1'b0;
            r_mem_rdata <= 32'h0000_0000;
            r_err_irq   <= 1'b0;
            r_err_addr  <= 32'h0000_0000;
            r_err_cause <= ERR_NONE;
        end else begin
            r_mem_ready <= w_decode_err | w_complete | w_abort;
            r_err_irq   <= w_decode_err | w_abort;
            if (w_decode_err || w_abort) begin
                r_mem_rdata <= ERR_RDATA;
            end else if (w_complete) begin
                r_mem_rdata <= w_sel_rdata;
            end else begin
                r_mem_rdata <= r_mem_rdata;
            end
            if (w_decode_err) begin
                r_err_cause <= ERR_DECODE;
                r_err_addr  <= mem_addr;
            end else if (w_abort) begin
                r_err_cause <= ERR_TIMEOUT;
                r_err_addr  <= r_s_addr;
            end else if (err_clear) begin
                r_err_cause <= ERR_NONE;
            end else begin
                r_err_cause <= r_err_cause;
            end
        end
    end

    assign mem_ready = r_mem_ready;
    assign mem_rdata = r_mem_rdata;
    assign s_valid   = r_s_valid;
    assign s_addr    = r_s_addr;
    assign s_wdata   = r_s_wdata;
    assign s_wstrb   = r_s_wstrb;
    assign err_irq   = r_err_irq;
    assign err_addr  = r_err_addr;
    assign err_cause = r_err_cause;

endmodule
